score_counter_rpt: RTL and testbench

//  Parametrised saturating/wrapping up/down score counter with press-and-hold auto-repeat.

---
 rtl/score_counter_rpt_pkg.sv | 19 +
 rtl/score_counter_rpt_btn_repeat.sv | 122 ++++++++++++
 rtl/score_counter_rpt.sv | 111 +++++++++++
 tb/tb_score_counter_rpt.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_counter_rpt_pkg.sv
// Shared definitions for the score counter: hold/repeat FSM encoding,
// default timing constants and a small integer helper.
package score_counter_rpt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  // Defaults assume a 50 MHz clock: 0.5 s before repeat, then 10 steps/s.
  localparam int HOLD_CYC_DEF = 25000000;
  localparam int RPT_CYC_DEF  = 5000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/score_counter_rpt_btn_repeat.sv
// Button edge detect plus press-and-hold auto-repeat.
// Emits single-cycle, mutually exclusive inc_o/dec_o requests.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | no button being tracked; waiting for a clean single press
//  HOLD    | button pressed, counting towards the first repeat
//  RPT     | auto-repeat active, one step every RPT_CYC cycles
module btn_repeat
  import score_counter_rpt_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int RPT_CYC  = RPT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic up_i,
  input  logic down_i,
  input  logic abort_i,
  output logic inc_o,
  output logic dec_o
);

  localparam int TW = $clog2(max_int(HOLD_CYC, RPT_CYC) + 1);
  localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYC);
  localparam logic [TW-1:0] RPT_T  = TW'(RPT_CYC);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  rpt_state_e    state_q;
  logic [TW-1:0] timer_q;
  logic          up_q;
  logic          down_q;
  logic          live_q;
  logic          dir_up_q;

  logic press_up;
  logic press_dn;
  logic held;
  logic fire;

  // Press qualification, hold tracking and the step request decode.
  // live_q masks the first cycle out of reset: the edge registers clear to 0,
  // so a button still held through reset would otherwise look like a new press.
  always_comb begin
    press_up = live_q & up_i & ~up_q & ~down_i;
    press_dn = live_q & down_i & ~down_q & ~up_i;
    held     = dir_up_q ? (up_i & ~down_i) : (down_i & ~up_i);
    fire     = 1'b0;
    case (state_q)
      ST_HOLD: fire = held & (timer_q == HOLD_T);
      ST_RPT:  fire = held & (timer_q == RPT_T);
      default: fire = 1'b0;
    endcase
    inc_o = 1'b0;
    dec_o = 1'b0;
    if (!abort_i) begin
      if (state_q == ST_IDLE) begin
        inc_o = press_up;
        dec_o = press_dn;
      end else if (fire) begin
        inc_o = dir_up_q;
        dec_o = ~dir_up_q;
      end
    end
  end

  // Edge registers, timer and hold FSM state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      live_q   <= 1'b0;
      dir_up_q <= 1'b0;
      state_q  <= ST_IDLE;
      timer_q  <= '0;
    end else begin
      up_q   <= up_i;
      down_q <= down_i;
      live_q <= 1'b1;
      if (abort_i) begin
        state_q <= ST_IDLE;
        timer_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (press_up || press_dn) begin
              state_q  <= ST_HOLD;
              timer_q  <= ONE_T;
              dir_up_q <= press_up;
            end
          end
          ST_HOLD: begin
            if (!held) begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end else if (timer_q == HOLD_T) begin
              state_q <= ST_RPT;
              timer_q <= ONE_T;
            end else begin
              timer_q <= timer_q + ONE_T;
            end
          end
          ST_RPT: begin
            if (!held) begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end else if (timer_q == RPT_T) begin
              timer_q <= ONE_T;
            end else begin
              timer_q <= timer_q + ONE_T;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/score_counter_rpt.sv
// Up/down score counter with saturate or wrap at the limits, clear/load,
// registered limit flags and a step strobe. Button timing lives in btn_repeat.
module score_counter_rpt
  import score_counter_rpt_pkg::*;
#(
  parameter int BW       = 7,
  parameter int MAX_VAL  = 99,
  parameter int WRAP     = 0,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int RPT_CYC  = RPT_CYC_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          up_i,
  input  logic          down_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  output logic [BW-1:0] counter_val_o,
  output logic          at_max_o,
  output logic          at_min_o,
  output logic          step_o
);

  localparam logic [BW-1:0] MAX_V = BW'(MAX_VAL);

  if (MAX_VAL >= (1 << BW)) begin : g_bad_max
    $error("score_counter_rpt: MAX_VAL does not fit in BW bits");
  end
  if (HOLD_CYC < 2) begin : g_bad_hold
    $error("score_counter_rpt: HOLD_CYC must be at least 2");
  end
  if (RPT_CYC < 1) begin : g_bad_rpt
    $error("score_counter_rpt: RPT_CYC must be at least 1");
  end

  logic          inc;
  logic          dec;
  logic [BW-1:0] cnt_q;
  logic [BW-1:0] cnt_nxt;
  logic          step_nxt;
  logic          at_max_q;
  logic          at_min_q;
  logic          step_q;

  btn_repeat #(
    .HOLD_CYC (HOLD_CYC),
    .RPT_CYC  (RPT_CYC)
  ) u_btn (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .up_i    (up_i),
    .down_i  (down_i),
    .abort_i (clr_i | load_i),
    .inc_o   (inc),
    .dec_o   (dec)
  );

  // Next count: clear beats load beats a step; limits either hold or wrap.
  always_comb begin
    cnt_nxt  = cnt_q;
    step_nxt = 1'b0;
    if (clr_i) begin
      cnt_nxt = '0;
    end else if (load_i) begin
      cnt_nxt = (load_val_i > MAX_V) ? MAX_V : load_val_i;
    end else if (inc) begin
      if (cnt_q == MAX_V) begin
        if (WRAP != 0) begin
          cnt_nxt  = '0;
          step_nxt = 1'b1;
        end
      end else begin
        cnt_nxt  = cnt_q + BW'(1);
        step_nxt = 1'b1;
      end
    end else if (dec) begin
      if (cnt_q == '0) begin
        if (WRAP != 0) begin
          cnt_nxt  = MAX_V;
          step_nxt = 1'b1;
        end
      end else begin
        cnt_nxt  = cnt_q - BW'(1);
        step_nxt = 1'b1;
      end
    end
  end

  // Count register; flags are decoded from the next value so they change
  // in the same edge as the count and never glitch on the outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
      step_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      at_max_q <= (cnt_nxt == MAX_V);
      at_min_q <= (cnt_nxt == '0);
      step_q   <= step_nxt;
    end
  end

  assign counter_val_o = cnt_q;
  assign at_max_o      = at_max_q;
  assign at_min_o      = at_min_q;
  assign step_o        = step_q;

endmodule

// File: tb/tb_score_counter_rpt.sv
// Directed bench for score_counter_rpt: a saturating and a wrapping instance
// with shortened hold/repeat timing.
module tb_score_counter_rpt;

  logic       clk;
  logic       rst_n;
  logic       up, down, clr, load;
  logic [6:0] lval;
  logic [6:0] cnt;
  logic       at_max, at_min, stp;

  logic       w_up, w_down, w_clr, w_load;
  logic [6:0] w_lval;
  logic [6:0] w_cnt;
  logic       w_at_max, w_at_min, w_stp;

  int n_tests = 0;
  int n_fail  = 0;

  score_counter_rpt #(
    .BW(7), .MAX_VAL(99), .WRAP(0), .HOLD_CYC(4), .RPT_CYC(2)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .up_i(up), .down_i(down),
    .clr_i(clr), .load_i(load), .load_val_i(lval),
    .counter_val_o(cnt), .at_max_o(at_max), .at_min_o(at_min), .step_o(stp)
  );

  score_counter_rpt #(
    .BW(7), .MAX_VAL(99), .WRAP(1), .HOLD_CYC(4), .RPT_CYC(2)
  ) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .up_i(w_up), .down_i(w_down),
    .clr_i(w_clr), .load_i(w_load), .load_val_i(w_lval),
    .counter_val_o(w_cnt), .at_max_o(w_at_max), .at_min_o(w_at_min), .step_o(w_stp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hold_cnt [9];
    int hold_stp [9];
    hold_cnt = '{1, 1, 1, 1, 2, 2, 3, 3, 4};
    hold_stp = '{1, 0, 0, 0, 1, 0, 1, 0, 1};

    rst_n = 1'b0; up = 1'b1; down = 1'b0; clr = 1'b0; load = 1'b0; lval = '0;
    w_up = 1'b0; w_down = 1'b0; w_clr = 1'b0; w_load = 1'b0; w_lval = '0;

    // 1. reset with up held
    tick(); tick();
    check("rst_cnt", cnt, 0);
    check("rst_at_min", at_min, 1);
    check("rst_at_max", at_max, 0);
    check("rst_step", stp, 0);
    check("rst_w_cnt", w_cnt, 0);
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_cnt", cnt, 0);
    check("post_rst_step", stp, 0);
    up = 1'b0;
    tick();

    // 2. single presses from 5
    load = 1'b1; lval = 7'd5;
    tick();
    load = 1'b0;
    check("load5", cnt, 5);
    up = 1'b1;
    tick();
    check("up_press_cnt", cnt, 6);
    check("up_press_step", stp, 1);
    up = 1'b0;
    tick();
    check("up_rel_cnt", cnt, 6);
    check("up_rel_step", stp, 0);
    down = 1'b1;
    tick();
    check("dn_press_cnt", cnt, 5);
    check("dn_press_step", stp, 1);
    down = 1'b0;
    tick();
    check("dn_rel_step", stp, 0);

    // 3. hold from 0: steps at 0, 4, 6, 8
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr0", cnt, 0);
    up = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("hold_cnt_%0d", k), cnt, hold_cnt[k]);
      check($sformatf("hold_step_%0d", k), stp, hold_stp[k]);
    end
    up = 1'b0;
    tick(); tick(); tick();
    check("hold_rel_cnt", cnt, 4);
    check("hold_rel_step", stp, 0);

    // 4. limits, saturating instance
    load = 1'b1; lval = 7'd99;
    tick();
    load = 1'b0;
    check("ld99_at_max", at_max, 1);
    up = 1'b1;
    tick();
    check("sat_up_cnt", cnt, 99);
    check("sat_up_step", stp, 0);
    check("sat_up_at_max", at_max, 1);
    up = 1'b0;
    load = 1'b1; lval = 7'd0;
    tick();
    load = 1'b0;
    down = 1'b1;
    tick();
    check("sat_dn_cnt", cnt, 0);
    check("sat_dn_step", stp, 0);
    check("sat_dn_at_min", at_min, 1);
    down = 1'b0;
    tick();

    // 4b. limits, wrapping instance
    w_load = 1'b1; w_lval = 7'd99;
    tick();
    w_load = 1'b0;
    w_up = 1'b1;
    tick();
    check("wrap_up_cnt", w_cnt, 0);
    check("wrap_up_step", w_stp, 1);
    check("wrap_up_at_min", w_at_min, 1);
    w_up = 1'b0;
    tick();
    w_down = 1'b1;
    tick();
    check("wrap_dn_cnt", w_cnt, 99);
    check("wrap_dn_step", w_stp, 1);
    check("wrap_dn_at_max", w_at_max, 1);
    w_down = 1'b0;
    tick();

    // 5. simultaneous buttons
    load = 1'b1; lval = 7'd10;
    tick();
    load = 1'b0;
    up = 1'b1; down = 1'b1;
    tick();
    check("both_cnt", cnt, 10);
    check("both_step", stp, 0);
    tick();
    down = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("one_left_cnt", cnt, 10);
    up = 1'b0;
    tick();
    up = 1'b1;
    tick();
    check("repress_cnt", cnt, 11);
    check("repress_step", stp, 1);
    up = 1'b0;
    tick();

    // 6. priority and clamp
    clr = 1'b1; load = 1'b1; lval = 7'd50; up = 1'b1;
    tick();
    clr = 1'b0; load = 1'b0;
    check("prio_cnt", cnt, 0);
    check("prio_step", stp, 0);
    tick(); tick();
    check("prio_after_cnt", cnt, 0);
    up = 1'b0;
    tick();
    load = 1'b1; lval = 7'd120;
    tick();
    load = 1'b0;
    check("clamp_cnt", cnt, 99);
    check("clamp_at_max", at_max, 1);
    check("load_step", stp, 0);
    load = 1'b1; lval = 7'd50;
    tick();
    load = 1'b0;
    check("load50_cnt", cnt, 50);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    up = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    check("rpt_before_clr", cnt, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("rpt_clr_cnt", cnt, 0);
    for (int k = 0; k < 8; k++) tick();
    check("rpt_clr_hold_cnt", cnt, 0);
    check("rpt_clr_hold_step", stp, 0);
    up = 1'b0;
    tick();

    // reset mid-hold aborts the repeat
    up = 1'b1;
    tick();
    check("pre_rst_cnt", cnt, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("rst_hold_cnt", cnt, 0);
    up = 1'b0;
    tick();
    up = 1'b1;
    tick();
    check("rst_repress_cnt", cnt, 1);
    up = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
